// File: rtl/regfile_bist.sv
// Built-in self-test sequencer for a 32 x 32-bit register file: writes a pattern
// to every register, reads it back in pairs and reports pass/fail statistics.
module regfile_bist #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic [ADDR_WIDTH-1:0] Ra,
  output logic [ADDR_WIDTH-1:0] Rb,
  output logic [ADDR_WIDTH-1:0] Rw,
  output logic                  RegWr,
  output logic [DATA_WIDTH-1:0] busW,
  input  logic [DATA_WIDTH-1:0] busA,
  input  logic [DATA_WIDTH-1:0] busB,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [1:0]            dbg_state
);

  // Handshake: start is a request level sampled only in IDLE (never queued);
  // done is a one-cycle pulse, and pass/fail_* /err_count stay valid until the next start.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_W    = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH+1:0] ERR_MAX_W = (ADDR_WIDTH + 2)'(NUM_REGS);

  state_e                state_q, state_d;
  logic [1:0]            pat_sel_q, pat_sel_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic                  reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] bus_w_q, bus_w_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [ADDR_WIDTH:0]   err_count_q, err_count_d;

  logic                  mm_a;
  logic                  mm_b;
  logic [ADDR_WIDTH+1:0] err_sum;
  logic [ADDR_WIDTH:0]   err_next;

  function automatic logic [DATA_WIDTH-1:0] pat_val(input logic [1:0]            sel,
                                                    input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    case (sel)
      2'b00:   v = DATA_WIDTH'(idx);
      2'b01:   v = ~DATA_WIDTH'(idx);
      2'b10:   v = idx[0] ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
      default: v = DATA_WIDTH'(1) << (32'(idx) % DATA_WIDTH);
    endcase
    return v;
  endfunction

  // Register 0 may be wired to zero in the file, so it can never read back the pattern.
  function automatic logic [DATA_WIDTH-1:0] exp_val(input logic [1:0]            sel,
                                                    input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = pat_val(sel, idx);
    if (ZERO_REG && (idx == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    pat_sel_d   = pat_sel_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rw_d        = rw_q;
    reg_wr_d    = reg_wr_q;
    bus_w_d     = bus_w_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_count_d = err_count_q;

    mm_a     = (state_q == READ) && (busA != exp_val(pat_sel_q, ra_q));
    mm_b     = (state_q == READ) && (busB != exp_val(pat_sel_q, rb_q));
    err_sum  = {1'b0, err_count_q} + (ADDR_WIDTH + 2)'(mm_a) + (ADDR_WIDTH + 2)'(mm_b);
    err_next = (err_sum > ERR_MAX_W) ? ERR_MAX : err_sum[ADDR_WIDTH:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WRITE;
          pat_sel_d   = pattern_sel;
          err_count_d = '0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          busy_d      = 1'b1;
          reg_wr_d    = 1'b1;
          rw_d        = '0;
          bus_w_d     = pat_val(pattern_sel, '0);
        end
      end
      WRITE: begin
        if (rw_q == LAST_W) begin
          state_d  = READ;
          reg_wr_d = 1'b0;
          ra_d     = '0;
          rb_d     = ADDR_WIDTH'(1);
        end else begin
          rw_d    = rw_q + ADDR_WIDTH'(1);
          bus_w_d = pat_val(pat_sel_q, rw_q + ADDR_WIDTH'(1));
        end
      end
      READ: begin
        err_count_d = err_next;
        // Only the first failing register of a test is recorded; port A wins a tie.
        if ((err_count_q == '0) && (mm_a || mm_b)) begin
          fail_addr_d = mm_a ? ra_q : rb_q;
          fail_data_d = mm_a ? busA : busB;
        end
        if (ra_q == LAST_PAIR) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_next == '0);
        end else begin
          ra_d = ra_q + ADDR_WIDTH'(2);
          rb_d = rb_q + ADDR_WIDTH'(2);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      pat_sel_q   <= 2'b00;
      ra_q        <= '0;
      rb_q        <= '0;
      rw_q        <= '0;
      reg_wr_q    <= 1'b0;
      bus_w_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rw_q        <= rw_d;
      reg_wr_q    <= reg_wr_d;
      bus_w_q     <= bus_w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_count_q <= err_count_d;
    end
  end

  assign Ra        = ra_q;
  assign Rb        = rb_q;
  assign Rw        = rw_q;
  assign RegWr     = reg_wr_q;
  assign busW      = bus_w_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test sequencer for the 32 x 32-bit register file. It drives the file's write port (Rw/RegWr/busW) and both read ports (Ra/Rb), and it checks busA/busB against a selectable data pattern. It sits between the register file and the debug/status logic, and it owns the register-file ports only while a test runs; an upstream mux selects it. It reports pass/fail, the first failing register and word, and a mismatch count.

## Interface
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, registers tested; even, equals 2**ADDR_WIDTH
- ZERO_REG, 0, 1 = register 0 is hardwired zero, so its expected read value is 0

Clock and reset: one clock; reset is synchronous and active-high.

- sys_clk  in  1  clock; all state updates on posedge
- sys_rst  in  1  synchronous, active-high reset
- start  in  1  test request; sampled only in IDLE
- pattern_sel  in  2  pattern, latched at start
- Ra  out  ADDR_WIDTH  read address A
- Rb  out  ADDR_WIDTH  read address B
- Rw  out  ADDR_WIDTH  write address
- RegWr  out  1  write enable
- busW  out  DATA_WIDTH  write data
- busA  in  DATA_WIDTH  data for Ra; combinational from the register file
- busB  in  DATA_WIDTH  data for Rb; combinational from the register file
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  no mismatches; valid from done until the next start
- fail_addr  out  ADDR_WIDTH  first failing register
- fail_data  out  DATA_WIDTH  value observed at fail_addr
- err_count  out  ADDR_WIDTH+1  total mismatching registers

## Operation
- Patterns pat(i):
  - 00: i, zero-extended
  - 01: ~i
  - 10: 0x5555_5555 for even i, 0xAAAA_AAAA for odd i
  - 11: 1 << (i mod DATA_WIDTH)
- Expected value exp(i) = pat(i), except exp(0) = 0 when ZERO_REG=1.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: goes to WRITE on start=1. On that edge it latches pattern_sel and clears err_count, pass, fail_addr and fail_data.
  - WRITE: write index w runs 0..NUM_REGS-1. Drives RegWr=1, Rw=w, busW=pat(w). After w=NUM_REGS-1, goes to READ.
  - READ: pair index k runs 0..NUM_REGS/2-1. Drives RegWr=0, Ra=2k, Rb=2k+1.
    - At the end of each cycle, compares busA with exp(2k) and busB with exp(2k+1).
    - err_count increments by the number of mismatches that cycle (0, 1 or 2).
    - On the first mismatch of the test, records fail_addr/fail_data. If both ports mismatch in that cycle, the Ra side (lower address) is recorded.
    - After the last pair, goes to DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). Goes to IDLE on the next edge.
- start is ignored in WRITE, READ and DONE; it is not queued.
- pass, fail_addr, fail_data and err_count hold their values in IDLE.
- err_count never wraps; its maximum is NUM_REGS.
- All outputs are registered; none is combinational from an input.

## Timing
- Reset values: state=IDLE, Ra=Rb=Rw=0, RegWr=0, busW=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, err_count=0.
- Cycle numbering below uses e0 = the edge that samples start=1 in IDLE.
- Writes:
  - Write w is driven during the cycle after edge e0+w.
  - The register file captures it at edge e0+w+1.
  - RegWr=1 lasts exactly NUM_REGS cycles.
- Reads:
  - At edge e0+NUM_REGS, RegWr falls and Ra=0, Rb=1 appear.
  - The write of register NUM_REGS-1 is captured on this same edge.
  - Pair k is compared at edge e0+NUM_REGS+k+1.
- Completion:
  - done goes high after edge e0+NUM_REGS+NUM_REGS/2 (e0+48 at defaults) and drops one cycle later.
  - busy is high from e0 until done rises.
- Reset mid-test: at the reset edge, state returns to IDLE and RegWr drops to 0. done is not pulsed and results are cleared. A new start is accepted on the very next IDLE edge.
- start=1 on the edge where DONE returns to IDLE is not sampled; start is sampled from the following edge.

## Test plan
- Fault-free register-file model, pattern 00, start at e0:
  - Exactly 32 write cycles with Rw=0..31 and busW=0..31.
  - done pulse after e0+48.
  - pass=1, err_count=0.
- Model with register 7 bit 3 stuck at 0, pattern 01:
  - fail_addr=7, fail_data=0xFFFF_FFF0, err_count=1, pass=0.
- Model with registers 4 and 5 both stuck at zero, pattern 10:
  - err_count=2, fail_addr=4, fail_data=0.
- Pattern 11, fault-free:
  - Register 31 is written with 0x8000_0000.
  - Register 0 is written with 0x0000_0001.
  - pass=1.
- Hardwired-zero model, pattern 01:
  - ZERO_REG=1 gives pass=1.
  - ZERO_REG=0 gives fail_addr=0, fail_data=0, err_count=1.
- Control cases:
  - start re-pulsed at write index 5: ignored, and the sequence is unchanged.
  - sys_rst asserted at write index 10: RegWr=0 and busy=0 on the next edge, and no done pulse.
  - A restart afterwards completes with pass=1.
